// File: rtl/tl_instruction_fetch_pkg.sv
// Constants shared by the fetch and decode stages: datapath width,
// special instruction words and the next-PC select encodings.
package tl_instruction_fetch_pkg;

  localparam int LEN = 32;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/tl_instruction_fetch_memoria_instrucciones.sv
// Word-addressed instruction memory: one posedge write port, one asynchronous read port.
// Contents are not reset, so a loaded program survives a pipeline reset.
module memoria_instrucciones #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // A same-cycle read of the address being written sees the old word.
  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/tl_instruction_fetch.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, instruction
// memory read and the IF/ID latch, with stall, flush, run enable and HALT detection.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | fetching normally; PC and IF/ID advance per stall/flush
// ST_HALTED | HALT latched into IF/ID; PC and IF/ID frozen until reset
module tl_instruction_fetch #(
  parameter int LEN         = 32,
  parameter int NB_ADDR_MEM = 10,
  parameter int NB_PC_SRC   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [NB_PC_SRC-1:0]   i_pc_src,
  input  logic [LEN-1:0]         i_branch_addr,
  input  logic [LEN-1:0]         i_jump_addr,
  input  logic [LEN-1:0]         i_jr_addr,
  input  logic                   i_wr_en,
  input  logic [NB_ADDR_MEM-1:0] i_wr_addr,
  input  logic [LEN-1:0]         i_wr_data,
  output logic [LEN-1:0]         o_instruccion,
  output logic [LEN-1:0]         o_adder_pc,
  output logic [LEN-1:0]         o_pc,
  output logic                   o_halt
);

  import tl_instruction_fetch_pkg::*;

  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] instr_q, instr_d;
  logic [LEN-1:0] adder_q, adder_d;
  fetch_state_e   state_q, state_d;

  logic [LEN-1:0] pc_plus4;
  logic [LEN-1:0] next_pc;
  logic [LEN-1:0] mem_rd;

  memoria_instrucciones #(
    .NB_DATA (LEN),
    .NB_ADDR (NB_ADDR_MEM)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (pc_q[NB_ADDR_MEM+1:2]),
    .o_rd_data (mem_rd)
  );

  assign pc_plus4 = pc_q + LEN'(4);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src_e'(i_pc_src[1:0]))
      PC_SRC_SEQ:    next_pc = pc_plus4;
      PC_SRC_BRANCH: next_pc = i_branch_addr;
      PC_SRC_JUMP:   next_pc = i_jump_addr;
      PC_SRC_JR:     next_pc = i_jr_addr;
      default:       next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    adder_d = adder_q;
    state_d = state_q;
    if (i_enable && (state_q == ST_RUN)) begin
      if (i_flush) begin
        // Wrong-path fetch: drop it (even a HALT) and redirect; stall loses to flush.
        pc_d    = next_pc;
        instr_d = LEN'(NOP);
        adder_d = '0;
      end else if (!i_stall) begin
        instr_d = mem_rd;
        adder_d = pc_plus4;
        if (mem_rd == LEN'(HALT)) begin
          state_d = ST_HALTED;
        end else begin
          pc_d = next_pc;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      adder_q <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      adder_q <= adder_d;
      state_q <= state_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_instruccion = instr_q;
  assign o_adder_pc    = adder_q;
  assign o_halt        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_tl_instruction_fetch.sv
// Bench for tl_instruction_fetch: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model of the fetch rules.
module tb_tl_instruction_fetch;

  localparam logic [31:0] W_NOP  = 32'h0000_0000;
  localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [1:0]  src = 2'b00;
  logic [31:0] br = '0, jp = '0, jr = '0;
  logic        we = 1'b0;
  logic [9:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [31:0] instr, adder, pc;
  logic        halt;

  tl_instruction_fetch #(.LEN(32), .NB_ADDR_MEM(10), .NB_PC_SRC(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_pc_src      (src),
    .i_branch_addr (br),
    .i_jump_addr   (jp),
    .i_jr_addr     (jr),
    .i_wr_en       (we),
    .i_wr_addr     (wa),
    .i_wr_data     (wd),
    .o_instruccion (instr),
    .o_adder_pc    (adder),
    .o_pc          (pc),
    .o_halt        (halt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_mem [1024];
  logic [31:0] m_pc, m_ins, m_add;
  bit          m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ins"},  instr, m_ins);
    chk({tag, ".add"},  adder, m_add);
    chk({tag, ".pc"},   pc,    m_pc);
    chk({tag, ".halt"}, {31'b0, halt}, {31'b0, m_halt});
  endtask

  task automatic idle();
    en = 1'b1; stall = 1'b0; flush = 1'b0; src = 2'b00; we = 1'b0;
  endtask

  // One clock with the currently driven inputs (rst high); inputs change only at negedge.
  task automatic tick(input string tag);
    logic [31:0] target, word;
    case (src)
      2'b00:   target = m_pc + 32'd4;
      2'b01:   target = br;
      2'b10:   target = jp;
      default: target = jr;
    endcase
    if (en && !m_halt) begin
      if (flush) begin
        m_pc  = target;
        m_ins = W_NOP;
        m_add = 32'd0;
      end else if (!stall) begin
        word  = m_mem[m_pc[11:2]];
        m_ins = word;
        m_add = m_pc + 32'd4;
        if (word == W_HALT) m_halt = 1'b1;
        else                m_pc   = target;
      end
    end
    if (we) m_mem[wa] = wd;
    @(posedge clk);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic areset(input string tag);
    we  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk({tag, ".ins0"},  instr, 32'd0);
    chk({tag, ".add0"},  adder, 32'd0);
    chk({tag, ".pc0"},   pc,    32'd0);
    chk({tag, ".halt0"}, {31'b0, halt}, 32'd0);
    m_pc = '0; m_ins = '0; m_add = '0; m_halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    m_mem[a] = d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] s_ins, s_add, s_pc, old_w, w;

    m_pc = '0; m_ins = '0; m_add = '0; m_halt = 1'b0;
    idle();
    @(negedge clk);
    chk("reset.ins", instr, 32'd0);
    chk("reset.pc",  pc,    32'd0);

    // program load while held in reset
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if (w == W_HALT) w = 32'h1234_5678;
      load(10'(i), w);
    end
    load(10'd0, 32'd11);
    load(10'd1, 32'd22);
    load(10'd2, 32'd33);
    load(10'd3, 32'd44);
    load(10'd16, 32'hABCD_0016);
    chk("reset_hold.ins", instr, 32'd0);
    rst = 1'b1;

    // sequential fetch
    tick("seq0"); chk("seq0.k", instr, 32'd11); chk("seq0.ka", adder, 32'd4);
    tick("seq1"); chk("seq1.k", instr, 32'd22); chk("seq1.ka", adder, 32'd8);

    // two-cycle stall
    stall = 1'b1;
    tick("stall0"); chk("stall0.k", instr, 32'd22);
    tick("stall1"); chk("stall1.ka", adder, 32'd8);
    stall = 1'b0;
    tick("resume"); chk("resume.k", instr, 32'd33); chk("resume.ka", adder, 32'd12);

    // flush with branch while also stalled
    flush = 1'b1; stall = 1'b1; src = 2'b01; br = 32'h40;
    tick("flush"); chk("flush.k", instr, 32'd0); chk("flush.ka", adder, 32'd0);
    idle();
    tick("branch"); chk("branch.k", instr, 32'hABCD_0016); chk("branch.ka", adder, 32'h44);

    // HALT at address 8
    en = 1'b0; we = 1'b1; wa = 10'd2; wd = W_HALT;
    tick("halt_wr");
    idle(); src = 2'b10; jp = 32'd8;
    tick("halt_jmp");
    idle();
    tick("halt"); chk("halt.k", {31'b0, halt}, 32'd1); chk("halt.kpc", pc, 32'd8);
    chk("halt.kins", instr, W_HALT);
    for (int i = 0; i < 10; i++) begin
      src = 2'($urandom_range(0, 3)); flush = 1'($urandom_range(0, 1));
      jp = $urandom; br = $urandom; jr = $urandom;
      tick("halt_hold"); chk("halt_hold.kpc", pc, 32'd8);
    end
    idle();
    areset("rst_halt");

    // HALT fetched under flush is discarded
    src = 2'b10; jp = 32'd8;
    tick("hf_jmp");
    idle(); flush = 1'b1;
    tick("hf_flush"); chk("hf_flush.k", {31'b0, halt}, 32'd0); chk("hf_flush.kpc", pc, 32'd12);
    idle();

    // run enable low for three cycles
    s_ins = instr; s_add = adder; s_pc = pc;
    en = 1'b0; src = 2'b10; jp = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick("dis");
      chk("dis.kins", instr, s_ins); chk("dis.kadd", adder, s_add); chk("dis.kpc", pc, s_pc);
    end

    // write to the word being fetched
    idle(); src = 2'b10; jp = 32'd20;
    tick("wr_jmp");
    old_w = m_mem[5];
    we = 1'b1; wa = 10'd5; wd = 32'h5555_AAAA;
    tick("wr_same"); chk("wr_same.k", instr, old_w);
    we = 1'b0;
    tick("wr_new"); chk("wr_new.k", instr, 32'h5555_AAAA);

    // asynchronous reset mid-run, memory retained
    idle(); src = 2'b10; jp = 32'h1C;
    tick("ar_jmp"); chk("ar_jmp.kpc", pc, 32'h1C);
    idle();
    areset("ar");
    tick("mem_keep"); chk("mem_keep.k", instr, 32'd11);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      src   = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      br    = $urandom_range(0, 4095);
      jp    = $urandom;
      jr    = $urandom_range(0, 255);
      we    = ($urandom_range(0, 3) == 0);
      wa    = 10'($urandom);
      wd    = ($urandom_range(0, 40) == 0) ? W_HALT : $urandom;
      tick("rnd");
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        idle();
        areset("rnd_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
